rx_control: RTL and testbench
=============================

Name: rx_control

Overview:
- Receive-side framer for the Ethernet MAC core; the counterpart of the transmit controller on the byte-wide PHY interface.
- Strips preamble and SFD, streams payload bytes (destination address through end of data) to the MAC client, and removes the 4 FCS bytes.
- Drives an external CRC-32 engine and checks the frame against the CRC residue.
- Reports per-frame status: CRC, PHY-error, length, runt.

Parameters:
- MIN_FRAME, 64: minimum legal frame length in bytes, counted from DA through FCS.
- MAX_FRAME, 1518: maximum legal frame length in bytes, counted from DA through FCS.
- CRC_RESIDUE, 32'hC704_DD7B: crc_result value after a good frame, FCS included.

Ports:
- clk  in  1  MAC clock
- rst_n  in  1  async active-low reset
- phy_rx_data  in  8  PHY receive byte
- phy_rx_dv  in  1  PHY data valid
- phy_rx_er  in  1  PHY receive error
- data_out  out  8  payload byte to client
- valid_out  out  1  data_out valid; no backpressure
- last_out  out  1  final payload byte of frame
- error_out  out  1  on last beat: OR of CRC, PHY and length errors
- crc_init  out  1  combinational; reset CRC engine
- crc_en  out  1  combinational; byte strobe to CRC engine
- crc_data  out  8  combinational; equals phy_rx_data
- crc_result  in  32  CRC engine state; covers all bytes strobed up to the previous cycle
- frame_done  out  1  one-cycle end-of-frame status pulse
- frame_crc_err  out  1  status, valid with frame_done
- frame_phy_err  out  1  status, valid with frame_done
- frame_len_err  out  1  status, valid with frame_done
- frame_runt  out  1  status, valid with frame_done
- frame_len  out  16  bytes after SFD (FCS included), saturating at 16'hFFFF

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: all registered outputs 0; state IDLE; counters and delay line cleared.
- IDLE:
  - phy_rx_dv=1 with byte 0x55 -> PREAMBLE.
  - phy_rx_dv=1 with any other byte, including 0xD5 -> DISCARD.
- PREAMBLE:
  - 0x55 -> stay.
  - 0xD5 -> DATA; crc_init=1 in that cycle.
  - Other byte -> DISCARD.
  - phy_rx_dv=0 -> IDLE with no output and no frame_done.
  - phy_rx_er is ignored in PREAMBLE.
- DATA:
  - Each byte with phy_rx_dv=1 asserts crc_en combinationally and enters a 4-byte delay line followed by a 1-byte hold register.
  - phy_rx_er=1 on any DATA cycle sets a sticky phy_err. Reception continues.
  - On the first cycle with phy_rx_dv=0: finalize the frame, then go to IDLE.
- DISCARD: no output and no CRC strobes; go to IDLE on phy_rx_dv=0.
- Output timing: payload byte k is the byte held when byte k+5 arrives. It emits registered, valid_out=1 the cycle after byte k+5 is on the PHY. The 4 bytes still in the delay line at end of frame are the FCS and are never emitted.
- Finalize: let c be the cycle where phy_rx_dv drops. At c+1, all of the following are asserted:
  - The held byte with valid_out=1, last_out=1, error_out.
  - frame_done.
  - All frame_* status bits.
  - crc_result is sampled in cycle c.
- Runt: a frame with ≤4 bytes after SFD produces no beats. At c+1, frame_done=1, frame_runt=1 and the other error bits are 0. This includes the case of 0 bytes after SFD.
- frame_crc_err = (crc_result != CRC_RESIDUE).
- frame_len_err = (frame_len < MIN_FRAME) or (frame_len > MAX_FRAME). Oversize frames are still streamed in full.
- Gap handling: minimum back-to-back gap is 1 cycle of phy_rx_dv=0. A new preamble may start in the cycle after c; finalize outputs are registered and do not block it.
- Reset mid-frame: all outputs drop to 0 immediately. No last_out is produced for the aborted frame. If phy_rx_dv is still high after reset, the first byte is not 0x55, so the block goes to DISCARD until phy_rx_dv falls.

Optional Feature:
- Macro: RX_STATS_EN.
- Defined:
  - Adds outputs stat_good[31:0] and stat_bad[31:0], reset to 0, wrapping modulo 2^32.
  - Updated the cycle after frame_done.
  - stat_good counts frames with all error bits 0.
  - stat_bad counts the rest, runts included.
- Undefined: the ports and counters do not exist.

Decomposition:
- Package eth_mac_pkg holds:
  - rx_state_t enum (IDLE, PREAMBLE, DATA, DISCARD).
  - Constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, FCS_BYTES=4.
  - The shared CRC residue constant.
- One natural sub-module, rx_fcs_strip: the 4-byte delay line plus hold register, with push/flush/last semantics.

Test Plan:
- Good frame: 7×0x55, 0xD5, then 60 bytes plus correct FCS. Expect 60 beats, last_out on beat 60, error_out=0, frame_len=64, all status bits 0.
- Same frame with one FCS bit flipped. Expect 60 beats, last_out with error_out=1, frame_crc_err=1.
- phy_rx_er pulsed on payload byte 10. Expect all bytes delivered, frame_phy_err=1, error_out=1 on the last beat.
- 0x55, 0xD5, then 3 bytes, then phy_rx_dv low. Expect 0 beats, frame_done with frame_runt=1. Back-to-back good frame after a 1-cycle gap is received intact.
- Preamble corrupted (0x55, 0x57, ...) and the no-preamble case (0xD5 first). Expect no beats, no frame_done, crc_en never asserted.
- rst_n asserted at payload byte 20 with phy_rx_dv held high. Expect outputs 0, no last_out for that frame, no output until the next proper preamble.

Source files
------------

// File: rtl/eth_mac_pkg.sv
// -----------------------------------------------------------------------------
// eth_mac_pkg
// Shared types and constants for the Ethernet MAC receive path.
//   rx_state_t      : receive framer state encoding
//   PREAMBLE_BYTE   : preamble octet (0x55)
//   SFD_BYTE        : start-of-frame delimiter octet (0xD5)
//   FCS_BYTES       : number of trailing FCS octets stripped from each frame
//   ETH_CRC_RESIDUE : CRC-32 register value after a good frame, FCS included
// -----------------------------------------------------------------------------
package eth_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DISCARD
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int unsigned FCS_BYTES       = 4;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704_DD7B;

endpackage

// File: rtl/rx_fcs_strip.sv
// -----------------------------------------------------------------------------
// rx_fcs_strip
// FCS_BYTES-deep byte delay line followed by a one-byte hold register. A byte
// leaves the hold register only once FCS_BYTES+1 newer bytes have been pushed
// behind it (or at end of frame), so the trailing FCS octets are never emitted.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_flush     : start of a new frame; empties the line
//   i_push      : i_data enters the line this cycle
//   i_last      : end of frame; emit the held byte (if any) as the last beat
//   i_data      : incoming byte
//   o_data      : registered output byte
//   o_valid     : o_data valid
//   o_last      : o_data is the final payload byte of the frame
//   o_hold_vld  : combinational; the hold register holds a payload byte
// -----------------------------------------------------------------------------
module rx_fcs_strip
    import eth_mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_flush,
    input  logic       i_push,
    input  logic       i_last,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_last,
    output logic       o_hold_vld
);

    localparam int unsigned LINE_W = FCS_BYTES * 8;
    localparam logic [2:0]  FULL   = 3'(FCS_BYTES + 1);

    logic [LINE_W-1:0] r_line;
    logic [7:0]        r_hold;
    logic [2:0]        r_fill;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_last;
    logic              w_full;

    // r_fill saturates at FCS_BYTES+1: from then on the hold register always
    // carries a byte that is known not to belong to the FCS.
    assign w_full = (r_fill == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line  <= '0;
            r_hold  <= '0;
            r_fill  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (i_flush) begin
                r_fill <= '0;
            end else if (i_push) begin
                r_hold <= r_line[LINE_W-1 -: 8];
                r_line <= {r_line[LINE_W-9:0], i_data};
                if (!w_full) begin
                    r_fill <= r_fill + 3'd1;
                end
                if (w_full) begin
                    r_data  <= r_hold;
                    r_valid <= 1'b1;
                end
            end else if (i_last && w_full) begin
                r_data  <= r_hold;
                r_valid <= 1'b1;
                r_last  <= 1'b1;
            end
        end
    end

    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_last     = r_last;
    assign o_hold_vld = w_full;

endmodule

// File: rtl/rx_control.sv
// -----------------------------------------------------------------------------
// rx_control
// Receive-side framer of the Ethernet MAC. Strips preamble/SFD, streams the
// frame from DA through end of data to the client, removes the 4 FCS bytes,
// drives an external CRC-32 engine and reports per-frame status.
//
// Optional feature: define RX_STATS_EN to add the stat_good/stat_bad frame
// counters and their output ports.
//
// Ports:
//   clk, rst_n             : MAC clock, asynchronous active-low reset
//   phy_rx_data/dv/er      : byte-wide PHY receive interface
//   data_out/valid_out     : payload byte stream to client (no backpressure)
//   last_out               : final payload byte of the frame
//   error_out              : on the last beat, OR of CRC/PHY/length errors
//   crc_init/crc_en/crc_data : combinational CRC engine controls
//   crc_result             : CRC engine state (bytes strobed before this cycle)
//   frame_done             : one-cycle end-of-frame pulse
//   frame_crc_err/phy_err/len_err/runt : status, valid with frame_done
//   frame_len              : bytes after SFD incl. FCS, saturating at 16'hFFFF
//   stat_good/stat_bad     : (RX_STATS_EN only) frame counters
// -----------------------------------------------------------------------------
module rx_control
    import eth_mac_pkg::*;
#(
    parameter int unsigned MIN_FRAME   = 64,
    parameter int unsigned MAX_FRAME   = 1518,
    parameter logic [31:0] CRC_RESIDUE = ETH_CRC_RESIDUE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  phy_rx_data,
    input  logic        phy_rx_dv,
    input  logic        phy_rx_er,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        last_out,
    output logic        error_out,
    output logic        crc_init,
    output logic        crc_en,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_result,
    output logic        frame_done,
    output logic        frame_crc_err,
    output logic        frame_phy_err,
    output logic        frame_len_err,
    output logic        frame_runt,
    output logic [15:0] frame_len
`ifdef RX_STATS_EN
    ,
    output logic [31:0] stat_good,
    output logic [31:0] stat_bad
`endif
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

    rx_state_t   r_state;
    rx_state_t   w_next;
    logic [15:0] r_len;
    logic        r_phy_err;
    logic        r_done;
    logic        r_crc_err;
    logic        r_phy_err_st;
    logic        r_len_err;
    logic        r_runt;
    logic [15:0] r_frame_len;
    logic        r_error;

    logic        w_push;
    logic        w_flush;
    logic        w_final;
    logic        w_hold_vld;
    logic        w_runt;
    logic        w_crc_bad;
    logic        w_len_bad;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_push   = 1'b0;
        w_flush  = 1'b0;
        w_final  = 1'b0;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (phy_rx_dv) begin
                    w_next = (phy_rx_data == PREAMBLE_BYTE) ? PREAMBLE : DISCARD;
                end
            end
            PREAMBLE: begin
                if (!phy_rx_dv) begin
                    w_next = IDLE;
                end else if (phy_rx_data == SFD_BYTE) begin
                    w_next   = DATA;
                    crc_init = 1'b1;
                    w_flush  = 1'b1;
                end else if (phy_rx_data != PREAMBLE_BYTE) begin
                    w_next = DISCARD;
                end
            end
            DATA: begin
                if (phy_rx_dv) begin
                    crc_en = 1'b1;
                    w_push = 1'b1;
                end else begin
                    w_final = 1'b1;
                    w_next  = IDLE;
                end
            end
            DISCARD: begin
                if (!phy_rx_dv) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign crc_data = phy_rx_data;

    // ------------------------------------------------------- FCS stripping
    rx_fcs_strip u_strip (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_last     (w_final),
        .i_data     (phy_rx_data),
        .o_data     (data_out),
        .o_valid    (valid_out),
        .o_last     (last_out),
        .o_hold_vld (w_hold_vld)
    );

    // ---------------------------------------------------- frame accounting
    // A frame is a runt exactly when the hold register never received a
    // payload byte, i.e. at most FCS_BYTES bytes followed the SFD.
    assign w_runt    = !w_hold_vld;
    assign w_crc_bad = (crc_result != CRC_RESIDUE);
    assign w_len_bad = (r_len < MIN_LEN) || (r_len > MAX_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len        <= '0;
            r_phy_err    <= 1'b0;
            r_done       <= 1'b0;
            r_crc_err    <= 1'b0;
            r_phy_err_st <= 1'b0;
            r_len_err    <= 1'b0;
            r_runt       <= 1'b0;
            r_frame_len  <= '0;
            r_error      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_flush) begin
                r_len     <= '0;
                r_phy_err <= 1'b0;
            end else if (w_push) begin
                if (r_len != '1) begin
                    r_len <= r_len + 16'd1;
                end
                if (phy_rx_er) begin
                    r_phy_err <= 1'b1;
                end
            end
            if (w_final) begin
                r_done       <= 1'b1;
                r_frame_len  <= r_len;
                r_runt       <= w_runt;
                r_crc_err    <= !w_runt && w_crc_bad;
                r_phy_err_st <= !w_runt && r_phy_err;
                r_len_err    <= !w_runt && w_len_bad;
                r_error      <= !w_runt && (w_crc_bad || r_phy_err || w_len_bad);
            end
        end
    end

    assign error_out     = r_error;
    assign frame_done    = r_done;
    assign frame_crc_err = r_crc_err;
    assign frame_phy_err = r_phy_err_st;
    assign frame_len_err = r_len_err;
    assign frame_runt    = r_runt;
    assign frame_len     = r_frame_len;

`ifdef RX_STATS_EN
    logic [31:0] r_stat_good;
    logic [31:0] r_stat_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_good <= '0;
            r_stat_bad  <= '0;
        end else if (r_done) begin
            if (r_crc_err || r_phy_err_st || r_len_err || r_runt) begin
                r_stat_bad <= r_stat_bad + 32'd1;
            end else begin
                r_stat_good <= r_stat_good + 32'd1;
            end
        end
    end

    assign stat_good = r_stat_good;
    assign stat_bad  = r_stat_bad;
`endif

endmodule

// File: tb/tb_rx_control.sv
// -----------------------------------------------------------------------------
// tb_rx_control
// Self-checking bench for rx_control: table of frame vectors plus hand-written
// sequences (runt followed by a back-to-back frame, reset in mid-frame).
// Includes a behavioural CRC-32 engine driven by crc_init/crc_en/crc_data.
// -----------------------------------------------------------------------------
module tb_rx_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  phy_rx_data = '0;
    logic        phy_rx_dv = 1'b0;
    logic        phy_rx_er = 1'b0;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        last_out;
    logic        error_out;
    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc_result;
    logic        frame_done;
    logic        frame_crc_err;
    logic        frame_phy_err;
    logic        frame_len_err;
    logic        frame_runt;
    logic [15:0] frame_len;
`ifdef RX_STATS_EN
    logic [31:0] stat_good;
    logic [31:0] stat_bad;
`endif

    always #5 clk = ~clk;

    rx_control #(
        .MIN_FRAME   (64),
        .MAX_FRAME   (1518),
        .CRC_RESIDUE (32'hC704_DD7B)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .phy_rx_data   (phy_rx_data),
        .phy_rx_dv     (phy_rx_dv),
        .phy_rx_er     (phy_rx_er),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .last_out      (last_out),
        .error_out     (error_out),
        .crc_init      (crc_init),
        .crc_en        (crc_en),
        .crc_data      (crc_data),
        .crc_result    (crc_result),
        .frame_done    (frame_done),
        .frame_crc_err (frame_crc_err),
        .frame_phy_err (frame_phy_err),
        .frame_len_err (frame_len_err),
        .frame_runt    (frame_runt),
        .frame_len     (frame_len)
`ifdef RX_STATS_EN
        ,
        .stat_good     (stat_good),
        .stat_bad      (stat_bad)
`endif
    );

    // ------------------------------------------------ CRC-32 engine model
    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = x[31-k];
        return r;
    endfunction

    logic [31:0] crc_reg = 32'hFFFF_FFFF;
    always @(posedge clk) begin
        if (crc_init)    crc_reg <= 32'hFFFF_FFFF;
        else if (crc_en) crc_reg <= crc_upd(crc_reg, crc_data);
    end
    assign crc_result = rev32(crc_reg);

    // ------------------------------------------------------------ monitor
    logic [7:0]  bq[$];
    logic        lq[$];
    logic        eq[$];
    logic [19:0] sq[$];
    int          crcen_cnt = 0;

    always @(negedge clk) begin
        if (valid_out) begin
            bq.push_back(data_out);
            lq.push_back(last_out);
            eq.push_back(error_out);
        end
        if (frame_done)
            sq.push_back({frame_crc_err, frame_phy_err, frame_len_err, frame_runt, frame_len});
        if (crc_en) crcen_cnt++;
    end

    task automatic clr_mon();
        bq.delete(); lq.delete(); eq.delete(); sq.delete();
        crcen_cnt = 0;
    endtask

    // ------------------------------------------------------------ checking
    int    total = 0;
    int    bad   = 0;
    string tag   = "init";

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, nm, act, exp);
        end
    endtask

    // ---------------------------------------------------------- stimulus
    logic [8:0] fb[$];       // {dv, data} per cycle
    logic [7:0] exp_pl[$];   // expected payload beats

    // kind: 0 normal preamble, 1 corrupted preamble, 2 SFD first, 3 runt (55 D5 + raw bytes)
    task automatic add_frame(input int kind, input int plen, input bit flip,
                             input int seed, input bit expect_pl);
        logic [31:0] c;
        logic [7:0]  b;
        case (kind)
            0: begin repeat (7) fb.push_back(9'h155); fb.push_back(9'h1D5); end
            1: begin fb.push_back(9'h155); fb.push_back(9'h157);
                     repeat (5) fb.push_back(9'h155); fb.push_back(9'h1D5); end
            2: fb.push_back(9'h1D5);
            default: begin fb.push_back(9'h155); fb.push_back(9'h1D5); end
        endcase
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < plen; i++) begin
            b = 8'(i * 7 + seed * 13 + 3);
            fb.push_back({1'b1, b});
            c = crc_upd(c, b);
            if (expect_pl) exp_pl.push_back(b);
        end
        if (kind != 3) begin
            c = ~c;
            for (int k = 0; k < 4; k++) begin
                b = c[8*k +: 8];
                fb.push_back({1'b1, b});
            end
            if (flip) fb[fb.size()-1] = fb[fb.size()-1] ^ 9'h004;
        end
    endtask

    task automatic drive(input int er_abs);
        for (int i = 0; i < fb.size(); i++) begin
            @(posedge clk); #1;
            {phy_rx_dv, phy_rx_data} = fb[i];
            phy_rx_er = (i == er_abs);
        end
        @(posedge clk); #1;
        phy_rx_dv = 1'b0; phy_rx_data = '0; phy_rx_er = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int ebeats, input int edones, input logic [19:0] est,
                             input int ecrcen, input bit eerr);
        int mism;
        int lastbad;
        mism = 0; lastbad = 0;
        chk("beats", 64'(bq.size()), 64'(ebeats));
        for (int i = 0; i < bq.size() && i < exp_pl.size(); i++)
            if (bq[i] !== exp_pl[i]) mism++;
        chk("beat_data", 64'(mism), 64'd0);
        for (int i = 0; i < lq.size(); i++) begin
            if (lq[i] !== (i == lq.size() - 1)) lastbad++;
            if (i != lq.size() - 1 && eq[i] !== 1'b0) lastbad++;
        end
        chk("last_err_pos", 64'(lastbad), 64'd0);
        if (eq.size() > 0) chk("error_out", 64'(eq[eq.size()-1]), 64'(eerr));
        chk("done_cnt", 64'(sq.size()), 64'(edones));
        if (sq.size() > 0 && edones > 0) chk("status", 64'(sq[0]), 64'(est));
        chk("crc_en_cnt", 64'(crcen_cnt), 64'(ecrcen));
    endtask

    typedef struct {
        int kind; int plen; bit flip; int er_pos;
        int beats; int dones;
        bit crc_e; bit phy_e; bit len_e; bit runt;
        int flen; int crcen; bit err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{0,   60, 1'b0, -1,   60, 1, 1'b0, 1'b0, 1'b0, 1'b0,   64,   64, 1'b0}; // good
        tbl[1] = '{0,   60, 1'b1, -1,   60, 1, 1'b1, 1'b0, 1'b0, 1'b0,   64,   64, 1'b1}; // FCS bit flip
        tbl[2] = '{0,   60, 1'b0, 10,   60, 1, 1'b0, 1'b1, 1'b0, 1'b0,   64,   64, 1'b1}; // rx_er on byte 10
        tbl[3] = '{1,   60, 1'b0, -1,    0, 0, 1'b0, 1'b0, 1'b0, 1'b0,    0,    0, 1'b0}; // corrupted preamble
        tbl[4] = '{2,   60, 1'b0, -1,    0, 0, 1'b0, 1'b0, 1'b0, 1'b0,    0,    0, 1'b0}; // SFD first
        tbl[5] = '{0,   59, 1'b0, -1,   59, 1, 1'b0, 1'b0, 1'b1, 1'b0,   63,   63, 1'b1}; // one short
        tbl[6] = '{0, 1514, 1'b0, -1, 1514, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1518, 1518, 1'b0}; // max legal
        tbl[7] = '{0, 1515, 1'b0, -1, 1515, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1519, 1519, 1'b1}; // oversize
        tbl[8] = '{0,    1, 1'b0, -1,    1, 1, 1'b0, 1'b0, 1'b1, 1'b0,    5,    5, 1'b1}; // 5 bytes: one beat
        tbl[9] = '{3,    0, 1'b0, -1,    0, 1, 1'b0, 1'b0, 1'b0, 1'b1,    0,    0, 1'b0}; // 0-byte runt

        // reset state
        tag = "reset";
        repeat (3) @(negedge clk);
        chk("outputs", 64'({data_out, valid_out, last_out, error_out, frame_done, frame_crc_err,
                            frame_phy_err, frame_len_err, frame_runt, frame_len, crc_init, crc_en}),
            64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        for (int v = 0; v < 10; v++) begin
            clr_mon(); fb.delete(); exp_pl.delete();
            add_frame(tbl[v].kind, tbl[v].plen, tbl[v].flip, v, tbl[v].kind == 0);
            drive(tbl[v].er_pos < 0 ? -1 : 8 + tbl[v].er_pos);
            tag = $sformatf("vec%0d", v);
            check_vec(tbl[v].beats, tbl[v].dones,
                      {tbl[v].crc_e, tbl[v].phy_e, tbl[v].len_e, tbl[v].runt, 16'(tbl[v].flen)},
                      tbl[v].crcen, tbl[v].err);
        end

        // 3-byte runt, 1-cycle gap, then a good frame back-to-back
        tag = "runt_b2b";
        clr_mon(); fb.delete(); exp_pl.delete();
        add_frame(3, 3, 1'b0, 11, 1'b0);
        fb.push_back(9'h000);
        add_frame(0, 60, 1'b0, 12, 1'b1);
        drive(-1);
        check_vec(60, 2, {4'b0001, 16'd3}, 67, 1'b0);
        if (sq.size() > 1) chk("status2", 64'(sq[1]), 64'({4'b0000, 16'd64}));

        // reset asserted while payload byte 20 is on the PHY, dv held high
        tag = "rst_mid";
        clr_mon(); fb.delete(); exp_pl.delete();
        add_frame(0, 60, 1'b0, 20, 1'b0);
        for (int i = 0; i < fb.size(); i++) begin
            @(posedge clk); #1;
            {phy_rx_dv, phy_rx_data} = fb[i];
            if (i == 29) rst_n = 1'b1;
            if (i == 28) begin
                #2 rst_n = 1'b0;
                #1 chk("outputs", 64'({data_out, valid_out, last_out, error_out, frame_done,
                                       frame_crc_err, frame_phy_err, frame_len_err, frame_runt,
                                       frame_len}), 64'd0);
                clr_mon();
            end
        end
        @(posedge clk); #1;
        phy_rx_dv = 1'b0; phy_rx_data = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("beats_after", 64'(bq.size()), 64'd0);
        chk("done_after", 64'(sq.size()), 64'd0);
        chk("crc_en_after", 64'(crcen_cnt), 64'd0);

        tag = "post_rst";
        clr_mon(); fb.delete(); exp_pl.delete();
        add_frame(0, 60, 1'b0, 21, 1'b1);
        drive(-1);
        check_vec(60, 1, {4'b0000, 16'd64}, 64, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
